// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the decode front end: opcodes, func3 codes and
// the registered bundle handed to the execute stage.
package rv32_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SR  = 3'b101;

    typedef struct packed {
        logic            valid;
        logic            is_store;
        logic            is_load;
        logic            is_branch;
        logic            is_jump;
        logic            is_reg;
        logic            is_alu;
        logic            illegal;
        logic [XLEN-1:0] operand_a;
        logic [XLEN-1:0] operand_b;
        logic [XLEN-1:0] store_data;
        logic [XLEN-1:0] branch_dest;
        logic [4:0]      dest;
        logic [2:0]      func3;
        logic            func7;
        logic [XLEN-1:0] curr_pc;
    } bundle_t;

endpackage

// File: rtl/regfile_2r1w.sv
// 32x32 integer register file, two combinational reads, one synchronous write.
// Optional write-through forwarding when DECODE_WB_BYPASS_EN is defined.
module regfile_2r1w
    import rv32_pkg::*;
(
    input  logic            clk,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] mem [NREGS];
    logic            wr_live;

    assign wr_live = we && (wa != 5'd0);

    always_ff @(posedge clk) begin
        if (wr_live)
            mem[wa] <= wd;
    end

    always_comb begin
        rd1 = (ra1 == 5'd0) ? '0 : mem[ra1];
        rd2 = (ra2 == 5'd0) ? '0 : mem[ra2];
`ifdef DECODE_WB_BYPASS_EN
        if (wr_live && (wa == ra1))
            rd1 = wd;
        if (wr_live && (wa == ra2))
            rd2 = wd;
`endif
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: register read, immediate generation and registered bundle
// with stall/flush. Build option DECODE_WB_BYPASS_EN enables regfile forwarding.
module decode_stage
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    output logic        is_store,
    output logic        is_load,
    output logic        is_branch,
    output logic        is_jump,
    output logic        is_reg,
    output logic        is_alu,
    output logic [31:0] operand_a,
    output logic [31:0] operand_b,
    output logic [31:0] store_data,
    output logic [31:0] branch_dest,
    output logic [4:0]  dest,
    output logic [2:0]  func3,
    output logic        func7,
    output logic [31:0] curr_pc,
    output logic        illegal
);

    logic [31:0] rs1_val, rs2_val;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    bundle_t     nxt, q;

    regfile_2r1w u_regfile (
        .clk (clk),
        .ra1 (instr[19:15]),
        .ra2 (instr[24:20]),
        .rd1 (rs1_val),
        .rd2 (rs2_val),
        .we  (wb_en),
        .wa  (wb_addr),
        .wd  (wb_data)
    );

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        nxt         = '0;
        nxt.valid   = in_valid;
        nxt.func3   = instr[14:12];
        nxt.curr_pc = pc;
        case (opcode)
            OPC_OP: begin
                nxt.is_alu    = 1'b1;
                nxt.operand_a = rs1_val;
                nxt.operand_b = rs2_val;
                nxt.func7     = instr[30];
                nxt.dest      = rd;
            end
            OPC_OP_IMM: begin
                // only shifts carry the modifier bit; addi with a negative imm must stay an add
                nxt.is_alu    = 1'b1;
                nxt.operand_a = rs1_val;
                nxt.operand_b = imm_i;
                nxt.func7     = (instr[14:12] == F3_SR) ? instr[30] : 1'b0;
                nxt.dest      = rd;
            end
            OPC_LUI: begin
                nxt.is_alu    = 1'b1;
                nxt.func3     = F3_ADD;
                nxt.operand_b = imm_u;
                nxt.dest      = rd;
            end
            OPC_AUIPC: begin
                nxt.is_alu    = 1'b1;
                nxt.func3     = F3_ADD;
                nxt.operand_a = pc;
                nxt.operand_b = imm_u;
                nxt.dest      = rd;
            end
            OPC_JAL: begin
                nxt.is_jump   = 1'b1;
                nxt.operand_a = imm_j;
                nxt.dest      = rd;
            end
            OPC_JALR: begin
                nxt.is_jump   = 1'b1;
                nxt.is_reg    = 1'b1;
                nxt.operand_a = rs1_val;
                nxt.operand_b = imm_i;
                nxt.dest      = rd;
            end
            OPC_BRANCH: begin
                nxt.is_branch   = 1'b1;
                nxt.operand_a   = rs1_val;
                nxt.operand_b   = rs2_val;
                nxt.branch_dest = imm_b;
            end
            OPC_LOAD: begin
                nxt.is_load   = 1'b1;
                nxt.operand_a = rs1_val;
                nxt.operand_b = imm_i;
                nxt.dest      = rd;
            end
            OPC_STORE: begin
                nxt.is_store   = 1'b1;
                nxt.operand_a  = rs1_val;
                nxt.operand_b  = imm_s;
                nxt.store_data = rs2_val;
            end
            default: nxt.illegal = 1'b1;
        endcase
        if (!in_valid) begin
            nxt.is_store  = 1'b0;
            nxt.is_load   = 1'b0;
            nxt.is_branch = 1'b0;
            nxt.is_jump   = 1'b0;
            nxt.is_reg    = 1'b0;
            nxt.is_alu    = 1'b0;
            nxt.illegal   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush)
            q <= '0;
        else if (!stall)
            q <= nxt;
    end

    assign out_valid   = q.valid;
    assign is_store    = q.is_store;
    assign is_load     = q.is_load;
    assign is_branch   = q.is_branch;
    assign is_jump     = q.is_jump;
    assign is_reg      = q.is_reg;
    assign is_alu      = q.is_alu;
    assign illegal     = q.illegal;
    assign operand_a   = q.operand_a;
    assign operand_b   = q.operand_b;
    assign store_data  = q.store_data;
    assign branch_dest = q.branch_dest;
    assign dest        = q.dest;
    assign func3       = q.func3;
    assign func7       = q.func7;
    assign curr_pc     = q.curr_pc;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed test-plan steps followed by
// randomized traffic checked against an instruction-level reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset, in_valid, stall, flush, wb_en;
    logic [31:0] instr, pc, wb_data;
    logic [4:0]  wb_addr;
    logic        out_valid, is_store, is_load, is_branch, is_jump, is_reg, is_alu, func7, illegal;
    logic [31:0] operand_a, operand_b, store_data, branch_dest, curr_pc;
    logic [4:0]  dest;
    logic [2:0]  func3;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr), .pc(pc),
        .stall(stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .is_store(is_store), .is_load(is_load), .is_branch(is_branch),
        .is_jump(is_jump), .is_reg(is_reg), .is_alu(is_alu), .operand_a(operand_a),
        .operand_b(operand_b), .store_data(store_data), .branch_dest(branch_dest),
        .dest(dest), .func3(func3), .func7(func7), .curr_pc(curr_pc), .illegal(illegal)
    );

`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic v, st, ld, br, jp, rg, alu, ill;
        logic [31:0] a, b, sd, bd;
        logic [4:0]  dest;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] pc;
    } bun_t;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mregs [32];
    bun_t        exp_b;
    bit          data_known;

    function automatic logic [31:0] sx(input logic [31:0] v, input int n);
        return 32'($signed(v << (32 - n)) >>> (32 - n));
    endfunction

    function automatic bun_t ref_dec(input logic [31:0] ins, input logic [31:0] p,
                                     input logic [31:0] r1, input logic [31:0] r2, input logic iv);
        bun_t        o;
        logic [31:0] rdx, f3x, iimm, simm, bimm, uimm, jimm;
        o    = '0;
        rdx  = (ins >> 7) & 31;
        f3x  = (ins >> 12) & 7;
        iimm = sx(ins >> 20, 12);
        simm = sx(((ins >> 25) << 5) | ((ins >> 7) & 31), 12);
        bimm = sx((((ins >> 31) & 1) << 12) | (((ins >> 7) & 1) << 11)
                  | (((ins >> 25) & 63) << 5) | (((ins >> 8) & 15) << 1), 13);
        uimm = ins & 32'hFFFF_F000;
        jimm = sx((((ins >> 31) & 1) << 20) | (((ins >> 12) & 255) << 12)
                  | (((ins >> 20) & 1) << 11) | (((ins >> 21) & 1023) << 1), 21);
        o.pc = p;
        o.f3 = f3x[2:0];
        case (ins & 127)
            32'h33: begin o.alu = 1; o.a = r1; o.b = r2; o.f7 = ins[30]; o.dest = rdx[4:0]; end
            32'h13: begin o.alu = 1; o.a = r1; o.b = iimm; o.f7 = (f3x == 5) && ins[30]; o.dest = rdx[4:0]; end
            32'h37: begin o.alu = 1; o.f3 = 0; o.b = uimm; o.dest = rdx[4:0]; end
            32'h17: begin o.alu = 1; o.f3 = 0; o.a = p; o.b = uimm; o.dest = rdx[4:0]; end
            32'h6F: begin o.jp = 1; o.a = jimm; o.dest = rdx[4:0]; end
            32'h67: begin o.jp = 1; o.rg = 1; o.a = r1; o.b = iimm; o.dest = rdx[4:0]; end
            32'h63: begin o.br = 1; o.a = r1; o.b = r2; o.bd = bimm; end
            32'h03: begin o.ld = 1; o.a = r1; o.b = iimm; o.dest = rdx[4:0]; end
            32'h23: begin o.st = 1; o.a = r1; o.b = simm; o.sd = r2; end
            default: o.ill = 1;
        endcase
        o.v = iv;
        if (!iv) {o.st, o.ld, o.br, o.jp, o.rg, o.alu, o.ill} = '0;
        return o;
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] idx, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
        if (idx == 0) return 32'd0;
        if (BYP && we && wa == idx) return wd;
        return mregs[idx];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_bundle(input string tag);
        check({tag, ".valid"},   32'(out_valid), 32'(exp_b.v));
        check({tag, ".flags"},   32'({is_store, is_load, is_branch, is_jump, is_reg, is_alu}),
                                 32'({exp_b.st, exp_b.ld, exp_b.br, exp_b.jp, exp_b.rg, exp_b.alu}));
        check({tag, ".illegal"}, 32'(illegal), 32'(exp_b.ill));
        if (data_known) begin
            check({tag, ".a"},     operand_a,   exp_b.a);
            check({tag, ".b"},     operand_b,   exp_b.b);
            check({tag, ".sd"},    store_data,  exp_b.sd);
            check({tag, ".bd"},    branch_dest, exp_b.bd);
            check({tag, ".dest"},  32'(dest),   32'(exp_b.dest));
            check({tag, ".func3"}, 32'(func3),  32'(exp_b.f3));
            check({tag, ".func7"}, 32'(func7),  32'(exp_b.f7));
            check({tag, ".pc"},    curr_pc,     exp_b.pc);
        end
    endtask

    // drive one cycle from a negedge, update the model, sample 1ns after the posedge
    task automatic cyc(input string tag, input logic rst, input logic iv, input logic [31:0] ins,
                       input logic [31:0] p, input logic st, input logic fl, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
        logic [31:0] r1, r2;
        reset = rst; in_valid = iv; instr = ins; pc = p; stall = st; flush = fl;
        wb_en = we; wb_addr = wa; wb_data = wd;
        r1 = mread(ins[19:15], we, wa, wd);
        r2 = mread(ins[24:20], we, wa, wd);
        if (rst || fl) begin
            exp_b = '0; data_known = 1;
        end else if (!st) begin
            exp_b = ref_dec(ins, p, r1, r2, iv); data_known = iv;
        end
        if (we && wa != 0) mregs[wa] = wd;
        @(posedge clk);
        #1;
        check_bundle(tag);
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] wa, input logic [31:0] wd);
        cyc("wr", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, wa, wd);
    endtask

    logic [31:0] saved_a, saved_pc;
    logic [6:0]  opcs [10];

    initial begin
        opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h7F};
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        data_known = 1; exp_b = '0;
        reset = 1; in_valid = 0; instr = 0; pc = 0; stall = 0; flush = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0;
        @(negedge clk);

        // reset state, while initialising the register file
        for (int i = 1; i < 32; i++)
            cyc("reset", 1'b1, 1'b1, 32'h006283B3, 32'h44, 1'b0, 1'b0, 1'b1, 5'(i), 32'(i * 32'h0101_0101));
        check("reset.valid_const", 32'(out_valid), 32'h0);

        wr(5'd5, 32'h10);
        wr(5'd6, 32'h3);

        cyc("add", 1'b0, 1'b1, 32'h006283B3, 32'h100, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        check("add.alu", 32'(is_alu), 32'h1);
        check("add.a", operand_a, 32'h10);
        check("add.b", operand_b, 32'h3);
        check("add.dest", 32'(dest), 32'h7);

        cyc("addi", 1'b0, 1'b1, 32'hFFF00093, 32'h104, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        check("addi.b", operand_b, 32'hFFFF_FFFF);
        check("addi.f7", 32'(func7), 32'h0);

        cyc("srai", 1'b0, 1'b1, 32'h4040D113, 32'h108, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        check("srai.f3", 32'(func3), 32'h5);
        check("srai.f7", 32'(func7), 32'h1);
        check("srai.b", operand_b, 32'h404);

        cyc("beq", 1'b0, 1'b1, 32'hFE628CE3, 32'h10C, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        check("beq.bd", branch_dest, 32'hFFFF_FFF8);
        check("beq.dest", 32'(dest), 32'h0);

        cyc("jalr", 1'b0, 1'b1, 32'h00008067, 32'h110, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        check("jalr.jr", 32'({is_jump, is_reg}), 32'h3);

        cyc("sw", 1'b0, 1'b1, 32'h0062A623, 32'h114, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        check("sw.b", operand_b, 32'd12);
        check("sw.sd", store_data, 32'd3);

        cyc("lui",   1'b0, 1'b1, 32'h123451B7, 32'h118, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        cyc("auipc", 1'b0, 1'b1, 32'h00001217, 32'h11C, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        check("auipc.a", operand_a, 32'h11C);
        cyc("jal",   1'b0, 1'b1, 32'h008000EF, 32'h120, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        check("jal.a", operand_a, 32'h8);
        cyc("lw",    1'b0, 1'b1, 32'h0082A383, 32'h124, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

        saved_a = operand_a; saved_pc = curr_pc;
        for (int i = 0; i < 3; i++)
            cyc("stall", 1'b0, 1'b1, 32'h006283B3 + 32'(i << 7), 32'h200 + 32'(i), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        check("stall.a_held", operand_a, saved_a);
        check("stall.pc_held", curr_pc, saved_pc);

        cyc("flush_stall", 1'b0, 1'b1, 32'h006283B3, 32'h300, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
        check("flush_stall.valid", 32'(out_valid), 32'h0);

        cyc("illegal", 1'b0, 1'b1, 32'h0000007F, 32'h304, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        check("illegal.flag", 32'(illegal), 32'h1);

        cyc("bypass", 1'b0, 1'b1, 32'h006283B3, 32'h308, 1'b0, 1'b0, 1'b1, 5'd5, 32'hAA);
        check("bypass.a", operand_a, BYP ? 32'hAA : 32'h10);
        cyc("after_wb", 1'b0, 1'b1, 32'h006283B3, 32'h30C, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        check("after_wb.a", operand_a, 32'hAA);

        wr(5'd0, 32'hDEAD_BEEF);
        cyc("x0_read", 1'b0, 1'b1, 32'h000003B3, 32'h310, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        check("x0_read.a", operand_a, 32'h0);

        cyc("rst_stall", 1'b1, 1'b1, 32'h006283B3, 32'h314, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        check("rst_stall.valid", 32'(out_valid), 32'h0);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            int          r;
            ins = $urandom;
            ins[6:0] = opcs[$urandom_range(0, 9)];
            r = $urandom_range(0, 99);
            cyc("rand", r < 3, $urandom_range(0, 3) != 0, ins, $urandom,
                $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8,
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
